mem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single unified instruction/data memory of the multicycle MIPS core. It lets the core's control FSM (port `cpu_*`) and a debug/program-loader port (`dbg_*`) share one synchronous memory with configurable access latency. It grants one requester at a time, drives the memory for a fixed number of wait cycles and returns a one-cycle acknowledge with registered read data. The core's FSM stalls in its fetch, read and write states until `cpu_ack`.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the shared MIPS instruction/data memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed cpu priority.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       we_q;
  logic       grant_dbg;
  logic       any_req;

  assign any_req = cpu_req | dbg_req;

`ifdef MEM_ARB_RR_EN
  // Last-grant history starts at dbg so that cpu wins the first tie.
  logic last_dbg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_dbg <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_dbg <= grant_dbg;
    end
  end

  assign grant_dbg = dbg_req & (~cpu_req | ~last_dbg);
`else
  assign grant_dbg = dbg_req & ~cpu_req;
`endif

  // Requester inputs are only looked at in IDLE; everything is latched at grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= grant_dbg;
            we_q      <= grant_dbg ? dbg_we    : cpu_we;
            mem_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            cnt       <= CNT_INIT;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!we_q) begin
              if (owner) begin
                dbg_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_en  = (state == ACCESS);
  assign mem_we  = mem_en & we_q;
  assign cpu_ack = (state == DONE) & ~owner;
  assign dbg_ack = (state == DONE) & owner;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grant order,
// memory contents and returned read data; a negedge monitor checks the DUT against it.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int WAIT = 3;

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_ack, dbg_ack, mem_en, mem_we, owner, busy;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem_arr [0:63];

  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t cur;
  int   en_cnt = 0;
  bit   idle_next = 1'b0;

  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] last_rd [0:1];
  logic          last_grant;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  function automatic logic [DW-1:0] memInit(input int i);
    return 32'h5A5A0000 + 32'(i) * 32'h00010013;
  endfunction

  // Behavioural memory: writes land at the clock edge, reads are combinational.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= memInit(i);
    end else if (mem_en && mem_we) begin
      mem_arr[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_arr[mem_addr[7:2]];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 64; i++) ref_mem[i] = memInit(i);
    last_rd[0] = '0;
    last_rd[1] = '0;
    last_grant = 1'b1;
  endtask

  // Monitor: every access cycle and every ack is compared with the queue head.
  always @(negedge clk) begin
    if (!reset_n) begin
      en_cnt    = 0;
      idle_next = 1'b0;
    end else begin
      if (mem_en) begin
        en_cnt++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_access", 32'(mem_en), 32'd0);
        end else begin
          cur = sb[0];
          checkOutput("mem_addr", mem_addr, cur.addr);
          checkOutput("mem_we", 32'(mem_we), 32'(cur.we));
          checkOutput("mem_wdata", mem_wdata, cur.wdata);
          checkOutput("owner", 32'(owner), 32'(cur.port));
          checkOutput("busy_access", 32'(busy), 32'd1);
        end
      end
      if (cpu_ack || dbg_ack) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_ack", {30'd0, dbg_ack, cpu_ack}, 32'd0);
        end else begin
          cur = sb.pop_front();
          checkOutput("ack_port", {30'd0, dbg_ack, cpu_ack}, cur.port ? 32'd2 : 32'd1);
          checkOutput(cur.port ? "dbg_rdata" : "cpu_rdata",
                      cur.port ? dbg_rdata : cpu_rdata, cur.rdata);
          checkOutput("access_cycles", 32'(en_cnt), 32'(WAIT));
          checkOutput("mem_en_done", 32'(mem_en), 32'd0);
        end
        en_cnt    = 0;
        idle_next = 1'b1;
      end else if (idle_next) begin
        checkOutput("busy_idle", 32'(busy), 32'd0);
        idle_next = 1'b0;
      end
    end
  end

  // Issues one round of requests; a port with count 2 keeps req high through its
  // first ack so that the arbiter sees it as a fresh request in the next IDLE cycle.
  task automatic applyStimulus(input int ccnt, input logic cwe, input logic [AW-1:0] caddr,
                               input logic [DW-1:0] cwd, input int dcnt, input logic dwe,
                               input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
    int            rem [0:1];
    int            left [0:1];
    logic          pwe [0:1];
    logic [AW-1:0] paddr [0:1];
    logic [DW-1:0] pwd [0:1];
    logic          p;
    exp_t          e;
    rem[0] = ccnt;  rem[1] = dcnt;
    pwe[0] = cwe;   pwe[1] = dwe;
    paddr[0] = caddr; paddr[1] = daddr;
    pwd[0] = cwd;   pwd[1] = dwd;
    left = rem;
    while (left[0] > 0 || left[1] > 0) begin
      if (left[0] > 0 && left[1] > 0) begin
`ifdef MEM_ARB_RR_EN
        p = ~last_grant;
`else
        p = 1'b0;
`endif
      end else begin
        p = (left[1] > 0);
      end
      e.port = p; e.we = pwe[p]; e.addr = paddr[p]; e.wdata = pwd[p];
      if (pwe[p]) begin
        ref_mem[paddr[p][7:2]] = pwd[p];
      end else begin
        last_rd[p] = ref_mem[paddr[p][7:2]];
      end
      e.rdata = last_rd[p];
      sb.push_back(e);
      last_grant = p;
      left[p]--;
    end
    cpu_req = (rem[0] > 0); cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = (rem[1] > 0); dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    for (int cyc = 0; cyc < 8 * (WAIT + 2) && (rem[0] > 0 || rem[1] > 0); cyc++) begin
      @(negedge clk);
      if (cpu_ack && rem[0] > 0) begin
        rem[0]--;
        if (rem[0] == 0) begin
          cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
        end
      end else if (mem_en && !owner && rem[0] == 1 && $urandom_range(0, 2) == 0) begin
        cpu_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        cpu_wdata = $urandom;
        if ($urandom_range(0, 1) == 1) cpu_req = 1'b0;
      end
      if (dbg_ack && rem[1] > 0) begin
        rem[1]--;
        if (rem[1] == 0) begin
          dbg_req = 1'b0; dbg_addr = $urandom; dbg_wdata = $urandom;
        end
      end else if (mem_en && owner && rem[1] == 1 && $urandom_range(0, 2) == 0) begin
        dbg_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        dbg_wdata = $urandom;
        if ($urandom_range(0, 1) == 1) dbg_req = 1'b0;
      end
    end
    if (rem[0] > 0 || rem[1] > 0) begin
      checkOutput("round_timeout", 32'(rem[0] + rem[1]), 32'd0);
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      sb.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] randAddr();
    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    resetModel();
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
    checkOutput("rst_dbg_rdata", dbg_rdata, 32'd0);
    checkOutput("rst_acks", {30'd0, dbg_ack, cpu_ack}, 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    applyStimulus(1, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h0, 32'h0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 1, 1'b1, 32'h40, 32'h12345678);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 1, 1'b0, 32'h40, 32'h0);
    applyStimulus(2, 1'b0, 32'h20, 32'h0, 1, 1'b0, 32'h40, 32'h0);
    applyStimulus(1, 1'b1, 32'h40, 32'hCAFEF00D, 2, 1'b0, 32'h40, 32'h0);

    for (int r = 0; r < 40; r++) begin
      int kind;
      kind = $urandom_range(0, 2);
      applyStimulus(kind != 1 ? $urandom_range(1, 2) : 0, 1'($urandom_range(0, 1)),
                    randAddr(), $urandom,
                    kind != 0 ? $urandom_range(1, 2) : 0, 1'($urandom_range(0, 1)),
                    randAddr(), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a dbg access: nothing may be acknowledged.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
    begin
      exp_t e;
      e.port = 1'b1; e.we = 1'b0; e.addr = 32'h8; e.wdata = dbg_wdata; e.rdata = '0;
      sb.push_back(e);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_owner", 32'(owner), 32'd0);
    checkOutput("midrst_acks", {30'd0, dbg_ack, cpu_ack}, 32'd0);
    checkOutput("midrst_dbg_rdata", dbg_rdata, 32'd0);
    dbg_req = 1'b0;
    sb.delete();
    resetModel();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1, 1'b0, 32'h8, 32'h0, 0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 32'h24, 32'h0, 1, 1'b1, 32'h24, 32'h0BADBEEF);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 1, 1'b0, 32'h24, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
